branch_predictor: RTL and testbench

Dynamic branch predictor and resolver for the RISC-V pipeline. It extends the fixed branch encoding (BR_NONE/BR_EQ/BR_NE) to the full signed and unsigned compare set. It holds a parametrised table of 2-bit saturating counters indexed by PC:
- fetch reads a taken/not-taken prediction;
- execute resolves the branch, trains the table and raises a registered mispredict pulse;
- saturating performance counters track branches and mispredictions.

---
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor and resolver. A table of 2-bit saturating counters,
// indexed by pc[IDX_W+1:2], provides a combinational taken/not-taken prediction
// for the fetch PC. The execute stage resolves the branch using the full signed
// and unsigned compare set, trains the table, and raises a registered one-cycle
// mispredict pulse. Saturating statistics counters track branches and
// mispredictions.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pred_pc           fetch PC to predict
//   pred_taken        prediction for pred_pc (combinational)
//   res_valid         resolve request this cycle
//   res_pc            PC of the resolving instruction
//   res_br_type       branch type code
//   res_rs1, res_rs2  compare operands
//   res_pred_taken    prediction carried down from fetch
//   res_taken         actual outcome (combinational)
//   mispredict        registered one-cycle flush pulse
//   clr_stats         synchronous clear of the statistics counters
//   br_count          resolved conditional branches (saturating)
//   mispred_count     mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic [2:0]       res_br_type,
  input  logic [WIDTH-1:0] res_rs1,
  input  logic [WIDTH-1:0] res_rs2,
  input  logic             res_pred_taken,
  output logic             res_taken,
  output logic             mispredict,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] br_count,
  output logic [WIDTH-1:0] mispred_count
);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_NE   = 3'b001,
    BR_EQ   = 3'b010,
    BR_RSV  = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } br_type_e;

  logic [1:0]       table_q [DEPTH];
  logic [1:0]       table_d [DEPTH];
  logic             mispredict_q, mispredict_d;
  logic [WIDTH-1:0] br_count_q, br_count_d;
  logic [WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             is_branch;
  logic             taken;
  logic [1:0]       cur_ctr, new_ctr;

  // Only pc[IDX_W+1:2] selects an entry; the remaining PC bits alias freely.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];

  // Read the registered table only: a same-cycle write is not bypassed.
  assign pred_taken = table_q[pred_idx][1];

  // Resolve: classify the request and evaluate the compare.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    is_branch = 1'b0;
    taken     = 1'b0;
    case (br_type_e'(res_br_type))
      BR_NE:  begin is_branch = res_valid; taken = (res_rs1 != res_rs2); end
      BR_EQ:  begin is_branch = res_valid; taken = (res_rs1 == res_rs2); end
      BR_LT:  begin is_branch = res_valid; taken = ($signed(res_rs1) <  $signed(res_rs2)); end
      BR_GE:  begin is_branch = res_valid; taken = ($signed(res_rs1) >= $signed(res_rs2)); end
      BR_LTU: begin is_branch = res_valid; taken = (res_rs1 <  res_rs2); end
      BR_GEU: begin is_branch = res_valid; taken = (res_rs1 >= res_rs2); end
      default: ; // BR_NONE and the reserved code are not branches
    endcase
  end

  // Outcome is only reported for a real branch.
  assign res_taken = is_branch & taken;

  // Saturating 2-bit counter training.
  always_comb begin
    cur_ctr = table_q[res_idx];
    if (taken) new_ctr = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
    else       new_ctr = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
  end

  always_comb begin
    table_d = table_q;
    if (is_branch) table_d[res_idx] = new_ctr;
  end

  // Flush pulse and statistics. clr_stats wins over a same-cycle increment but
  // does not block the table update above.
  always_comb begin
    mispredict_d    = is_branch & (taken != res_pred_taken);
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (clr_stats) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else begin
      if (is_branch && !(&br_count_q))         br_count_d      = br_count_q + 1'b1;
      if (mispredict_d && !(&mispred_count_q)) mispred_count_d = mispred_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is a real reset target here (every entry must read
      // weakly not-taken out of reset), so it is built from flops, not a RAM.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
      mispredict_q    <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its pre-edge inputs regardless of statement order.
      table_q         <= table_d;
      mispredict_q    <= mispredict_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed and randomized checks of branch_predictor against a behavioural
// model (integer counter array, integer statistics, arithmetic compares).
// A second, narrow instance (WIDTH=4, DEPTH=4) exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int W = 32;
  localparam int D = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pred_pc, res_pc, res_rs1, res_rs2;
  logic          pred_taken, res_valid, res_pred_taken, res_taken, mispredict, clr_stats;
  logic [2:0]    res_br_type;
  logic [W-1:0]  br_count, mispred_count;

  // narrow instance
  logic [3:0]    s_pred_pc, s_res_pc, s_rs1, s_rs2, s_br_count, s_mispred_count;
  logic          s_pred_taken, s_res_valid, s_res_pred_taken, s_res_taken, s_mispredict, s_clr;
  logic [2:0]    s_br_type;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model
  int              mcnt [D];
  longint unsigned m_br, m_mp;
  bit              m_misp;
  localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;

  branch_predictor #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_br_type(res_br_type),
    .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pred_taken(res_pred_taken),
    .res_taken(res_taken), .mispredict(mispredict), .clr_stats(clr_stats),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predictor #(.WIDTH(4), .DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pred_pc(s_pred_pc), .pred_taken(s_pred_taken),
    .res_valid(s_res_valid), .res_pc(s_res_pc), .res_br_type(s_br_type),
    .res_rs1(s_rs1), .res_rs2(s_rs2), .res_pred_taken(s_res_pred_taken),
    .res_taken(s_res_taken), .mispredict(s_mispredict), .clr_stats(s_clr),
    .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input logic [31:0] x);
    return x[31] ? longint'(x) - 64'sh1_0000_0000 : longint'(x);
  endfunction

  function automatic bit m_is_branch(input bit v, input logic [2:0] bt);
    return v && (int'(bt) inside {1, 2, 4, 5, 6, 7});
  endfunction

  function automatic bit m_cmp(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
    case (int'(bt))
      1: return a != b;
      2: return a == b;
      4: return sval(a) <  sval(b);
      5: return sval(a) >= sval(b);
      6: return longint'(a) <  longint'(b);
      7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % D);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return mcnt[m_idx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) mcnt[i] = 1;
    m_br = 0; m_mp = 0; m_misp = 0;
  endtask

  // One cycle: called just after a falling edge, returns just after the next one.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic [2:0] bt,
                         input logic [31:0] a, input logic [31:0] b, input logic pt,
                         input logic v, input logic [31:0] ppc, input logic clr);
    bit br, tk;
    res_valid = v; res_pc = pc; res_br_type = bt; res_rs1 = a; res_rs2 = b;
    res_pred_taken = pt; pred_pc = ppc; clr_stats = clr;
    br = m_is_branch(v, bt);
    tk = br && m_cmp(bt, a, b);
    #1;
    check({tag, ".pred_pre"}, 64'(pred_taken), 64'(m_pred(ppc)));
    check({tag, ".res_taken"}, 64'(res_taken), 64'(tk));
    if (br) begin
      if (tk) mcnt[m_idx(pc)] = (mcnt[m_idx(pc)] == 3) ? 3 : mcnt[m_idx(pc)] + 1;
      else    mcnt[m_idx(pc)] = (mcnt[m_idx(pc)] == 0) ? 0 : mcnt[m_idx(pc)] - 1;
    end
    m_misp = br && (tk != pt);
    if (clr) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (br && m_br < CMAX)     m_br++;
      if (m_misp && m_mp < CMAX) m_mp++;
    end
    @(posedge clk); #1;
    check({tag, ".mispredict"}, 64'(mispredict), 64'(m_misp));
    check({tag, ".br_count"}, 64'(br_count), m_br);
    check({tag, ".mispred_count"}, 64'(mispred_count), m_mp);
    check({tag, ".pred_post"}, 64'(pred_taken), 64'(m_pred(ppc)));
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [31:0] ppc);
    resolve(tag, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, ppc, 1'b0);
  endtask

  logic [31:0] opnds [6];

  initial begin
    rst_n = 1'b0;
    pred_pc = 32'h100; res_valid = 0; res_pc = 0; res_br_type = 0;
    res_rs1 = 0; res_rs2 = 0; res_pred_taken = 0; clr_stats = 0;
    s_pred_pc = 0; s_res_valid = 0; s_res_pc = 0; s_br_type = 0;
    s_rs1 = 0; s_rs2 = 0; s_res_pred_taken = 0; s_clr = 0;
    model_reset();

    // reset state
    #12;
    check("rst.pred_taken", 64'(pred_taken), 64'd0);
    check("rst.mispredict", 64'(mispredict), 64'd0);
    check("rst.br_count", 64'(br_count), 64'd0);
    check("rst.mispred_count", 64'(mispred_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // four taken BR_EQ resolves predicted not-taken
    for (int i = 0; i < 4; i++)
      resolve("eq_train", 32'h100, 3'b010, 32'd5, 32'd5, 1'b0, 1'b1, 32'h100, 1'b0);
    check("eq_train.br_count_4", 64'(br_count), 64'd4);
    check("eq_train.mispred_count_4", 64'(mispred_count), 64'd4);
    idle("eq_after", 32'h100);
    check("eq_after.mispredict_low", 64'(mispredict), 64'd0);
    check("eq_after.pred_1", 64'(pred_taken), 64'd1);

    // compare set, rs1=-1 rs2=1
    resolve("cmp_lt",   32'h500, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h500, 1'b0);
    resolve("cmp_ltu",  32'h504, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h504, 1'b0);
    resolve("cmp_ge",   32'h508, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h508, 1'b0);
    resolve("cmp_geu",  32'h50C, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h50C, 1'b0);
    resolve("cmp_ne",   32'h510, 3'b001, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h510, 1'b0);
    resolve("cmp_rsv",  32'h514, 3'b011, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h514, 1'b0);
    resolve("cmp_none", 32'h518, 3'b000, 32'd3, 32'd3, 1'b1, 1'b1, 32'h518, 1'b0);

    // aliasing: index 0 is at 11
    idle("alias_200", 32'h200);
    idle("alias_104", 32'h104);

    // same-cycle read of the entry being written
    resolve("same_cycle", 32'h40, 3'b010, 32'd7, 32'd7, 1'b1, 1'b1, 32'h40, 1'b0);

    // clr_stats together with a branch; table still trains (0x80: 01 -> 10)
    resolve("clr", 32'h80, 3'b001, 32'd1, 32'd2, 1'b0, 1'b1, 32'h80, 1'b1);
    check("clr.br_zero", 64'(br_count), 64'd0);

    // back-to-back mispredicts then a correct prediction
    resolve("b2b_0", 32'h600, 3'b110, 32'd1, 32'd2, 1'b0, 1'b1, 32'h600, 1'b0);
    resolve("b2b_1", 32'h604, 3'b101, 32'd2, 32'd1, 1'b0, 1'b1, 32'h600, 1'b0);
    resolve("b2b_2", 32'h608, 3'b010, 32'd1, 32'd2, 1'b0, 1'b1, 32'h600, 1'b0);

    // randomized traffic
    opnds[0] = 32'h0; opnds[1] = 32'h1; opnds[2] = 32'hFFFF_FFFF;
    opnds[3] = 32'h8000_0000; opnds[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      opnds[5] = $urandom;
      a = opnds[$urandom_range(0, 5)];
      b = ($urandom_range(0, 3) == 0) ? a : opnds[$urandom_range(0, 5)];
      resolve("rand", $urandom_range(0, 2047), 3'($urandom_range(0, 7)), a, b,
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
              $urandom_range(0, 2047), ($urandom_range(0, 31) == 0));
    end

    // reset asserted mid-stream with a mispredict pending
    resolve("pre_rst", 32'h3F0, 3'b001, 32'd1, 32'd2, 1'b0, 1'b1, 32'h3F0, 1'b0);
    resolve("pre_rst2", 32'h100, 3'b010, 32'd1, 32'd1, 1'b0, 1'b1, 32'h100, 1'b0);
    res_valid = 1'b1; res_pc = 32'h3F0; res_br_type = 3'b001;
    res_rs1 = 32'd1; res_rs2 = 32'd2; res_pred_taken = 1'b0; pred_pc = 32'h3F0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.mispredict", 64'(mispredict), 64'd0);
    check("midrst.br_count", 64'(br_count), 64'd0);
    check("midrst.mispred_count", 64'(mispred_count), 64'd0);
    check("midrst.pred_taken", 64'(pred_taken), 64'd0);
    @(posedge clk); #1;
    check("midrst.hold_mispredict", 64'(mispredict), 64'd0);
    @(negedge clk);
    res_valid = 1'b0;
    rst_n = 1'b1;
    idle("post_rst", 32'h100);

    // saturation on the narrow instance: both counters hold at 4'hF
    for (int i = 0; i < 20; i++) begin
      s_res_valid = 1'b1; s_br_type = 3'b010; s_rs1 = 4'd0; s_rs2 = 4'd0;
      s_res_pred_taken = 1'b0; s_res_pc = 4'(i * 4);
      @(posedge clk); #1;
      check("sat.br_count", 64'(s_br_count), 64'((i + 1 > 15) ? 15 : i + 1));
      check("sat.mispred_count", 64'(s_mispred_count), 64'((i + 1 > 15) ? 15 : i + 1));
      check("sat.mispredict", 64'(s_mispredict), 64'd1);
      @(negedge clk);
    end
    s_res_valid = 1'b0;
    s_pred_pc = 4'h4;
    #1;
    check("sat.pred_taken", 64'(s_pred_taken), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
